// File: rtl/operator_sched_if.sv
// Bundle of requester, operator and response signals around operator_sched.
// slave = the scheduler; master = requesters, response consumer and the operator unit.
interface operator_sched_if #(
  parameter int unsigned OPC_W = 5,
  parameter int unsigned DAT_W = 3,
  parameter int unsigned RES_W = 6
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPC_W-1:0] req0_opcode;
  logic             req0_a;
  logic             req0_b;
  logic [DAT_W-1:0] req0_c;
  logic [DAT_W-1:0] req0_d;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPC_W-1:0] req1_opcode;
  logic             req1_a;
  logic             req1_b;
  logic [DAT_W-1:0] req1_c;
  logic [DAT_W-1:0] req1_d;

  logic [OPC_W-1:0] op_opcode;
  logic             op_a;
  logic             op_b;
  logic [DAT_W-1:0] op_c;
  logic [DAT_W-1:0] op_d;
  logic             op_y;
  logic [RES_W-1:0] op_r;
  logic [DAT_W-1:0] op_av;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic             rsp_y;
  logic [RES_W-1:0] rsp_r;
  logic [DAT_W-1:0] rsp_a;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b, req0_c, req0_d,
    input  req1_valid, req1_opcode, req1_a, req1_b, req1_c, req1_d,
    output req0_ready, req1_ready,
    output op_opcode, op_a, op_b, op_c, op_d,
    input  op_y, op_r, op_av,
    output rsp_valid, rsp_id, rsp_y, rsp_r, rsp_a, rsp_err, busy,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b, req0_c, req0_d,
    output req1_valid, req1_opcode, req1_a, req1_b, req1_c, req1_d,
    input  req0_ready, req1_ready,
    input  op_opcode, op_a, op_b, op_c, op_d,
    output op_y, op_r, op_av,
    input  rsp_valid, rsp_id, rsp_y, rsp_r, rsp_a, rsp_err, busy,
    output rsp_ready
  );
endinterface

// File: rtl/operator_sched.sv
// Two-requester round-robin scheduler sharing one combinational operator unit.
// One command in flight: issue operands, let them settle, capture and return a tagged response.
module operator_sched #(
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned DAT_W   = 3,
  parameter int unsigned RES_W   = 6,
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned OPC_MAX = 22
) (
  input logic             clk,
  input logic             rst,
  operator_sched_if.slave bus
);
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OPC_W-1:0] op_opcode_q, op_opcode_d;
  logic             op_a_q, op_a_d;
  logic             op_b_q, op_b_d;
  logic [DAT_W-1:0] op_c_q, op_c_d;
  logic [DAT_W-1:0] op_d_q, op_d_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_y_q, rsp_y_d;
  logic [RES_W-1:0] rsp_r_q, rsp_r_d;
  logic [DAT_W-1:0] rsp_a_q, rsp_a_d;
  logic             rsp_err_q, rsp_err_d;

  logic             gnt_any;
  logic             gnt_id;
  logic             accept;
  logic [OPC_W-1:0] sel_opcode;
  logic             sel_a;
  logic             sel_b;
  logic [DAT_W-1:0] sel_c;
  logic [DAT_W-1:0] sel_d;

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    gnt_any    = bus.req0_valid | bus.req1_valid;
    gnt_id     = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    sel_opcode = gnt_id ? bus.req1_opcode : bus.req0_opcode;
    sel_a      = gnt_id ? bus.req1_a      : bus.req0_a;
    sel_b      = gnt_id ? bus.req1_b      : bus.req0_b;
    sel_c      = gnt_id ? bus.req1_c      : bus.req0_c;
    sel_d      = gnt_id ? bus.req1_d      : bus.req0_d;
  end

  assign accept         = (state_q == StIdle) && gnt_any;
  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept && gnt_id;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op_opcode_d  = op_opcode_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_c_d       = op_c_q;
    op_d_d       = op_d_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_y_d      = rsp_y_q;
    rsp_r_d      = rsp_r_q;
    rsp_a_d      = rsp_a_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          last_grant_d = gnt_id;
          rsp_id_d     = gnt_id;
          if (sel_opcode <= OPC_W'(OPC_MAX)) begin
            op_opcode_d = sel_opcode;
            op_a_d      = sel_a;
            op_b_d      = sel_b;
            op_c_d      = sel_c;
            op_d_d      = sel_d;
            cnt_d       = CntW'(SETTLE - 1);
            state_d     = StWait;
          end else begin
            // Rejected: operator keeps its previous operands, response carries zeros.
            rsp_err_d   = 1'b1;
            rsp_y_d     = 1'b0;
            rsp_r_d     = '0;
            rsp_a_d     = '0;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          rsp_y_d     = bus.op_y;
          rsp_r_d     = bus.op_r;
          rsp_a_d     = bus.op_av;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      op_opcode_q  <= '0;
      op_a_q       <= 1'b0;
      op_b_q       <= 1'b0;
      op_c_q       <= '0;
      op_d_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= 1'b0;
      rsp_r_q      <= '0;
      rsp_a_q      <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op_opcode_q  <= op_opcode_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_c_q       <= op_c_d;
      op_d_q       <= op_d_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y_q      <= rsp_y_d;
      rsp_r_q      <= rsp_r_d;
      rsp_a_q      <= rsp_a_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.op_opcode = op_opcode_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_c      = op_c_q;
  assign bus.op_d      = op_d_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_a     = rsp_a_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_operator_sched.sv
// Bench for operator_sched: vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level scoreboard.
module tb_operator_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic corrupt3 = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  operator_sched_if #(.OPC_W(5), .DAT_W(3), .RES_W(6)) bus1 ();
  operator_sched_if #(.OPC_W(5), .DAT_W(3), .RES_W(6)) bus3 ();

  operator_sched #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  operator_sched #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Operator unit model: Y = opc[0] ? a&b : a^b, R = {c,d} + opc, A = c^d.
  function automatic logic f_y(input logic [4:0] o, input logic a, input logic b);
    return o[0] ? (a & b) : (a ^ b);
  endfunction
  function automatic logic [5:0] f_r(input logic [4:0] o, input logic [2:0] c,
                                     input logic [2:0] d);
    return {c, d} + {1'b0, o};
  endfunction
  // Expected response {err, y, r, a}.
  function automatic logic [10:0] f_rsp(input logic [4:0] o, input logic a, input logic b,
                                        input logic [2:0] c, input logic [2:0] d);
    if (o > 5'd22) return {1'b1, 10'd0};
    return {1'b0, f_y(o, a, b), f_r(o, c, d), c ^ d};
  endfunction

  assign bus1.op_y  = f_y(bus1.op_opcode, bus1.op_a, bus1.op_b);
  assign bus1.op_r  = f_r(bus1.op_opcode, bus1.op_c, bus1.op_d);
  assign bus1.op_av = bus1.op_c ^ bus1.op_d;
  assign bus3.op_y  = f_y(bus3.op_opcode, bus3.op_a, bus3.op_b) ^ corrupt3;
  assign bus3.op_r  = f_r(bus3.op_opcode, bus3.op_c, bus3.op_d) ^ (corrupt3 ? 6'h3f : 6'h00);
  assign bus3.op_av = (bus3.op_c ^ bus3.op_d) ^ (corrupt3 ? 3'h7 : 3'h0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic       id;
    logic [4:0] opc;
    logic       a;
    logic       b;
    logic [2:0] c;
    logic [2:0] d;
    logic       err;
    logic       y;
    logic [5:0] r;
    logic [2:0] av;
    logic [4:0] op_opc;
    int         lat;
  } vec_t;

  task automatic drive1(input logic id, input logic [4:0] o, input logic a, input logic b,
                        input logic [2:0] c, input logic [2:0] d);
    bus1.req0_valid = !id; bus1.req0_opcode = o; bus1.req0_a = a; bus1.req0_b = b;
    bus1.req0_c = c; bus1.req0_d = d;
    bus1.req1_valid = id;  bus1.req1_opcode = o; bus1.req1_a = a; bus1.req1_b = b;
    bus1.req1_c = c; bus1.req1_d = d;
  endtask

  task automatic drain1();
    int n = 0;
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    bus1.rsp_ready  = 1'b1;
    while (bus1.busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", bus1.busy, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, bus1.busy, 0);
    chk({tag, "_rsp_valid"}, bus1.rsp_valid, 0);
    chk({tag, "_op"}, {bus1.op_opcode, bus1.op_a, bus1.op_b, bus1.op_c, bus1.op_d}, 0);
    chk({tag, "_rsp"}, {bus1.rsp_id, bus1.rsp_y, bus1.rsp_r, bus1.rsp_a, bus1.rsp_err}, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    bus1.rsp_ready = 1'b1;
    drive1(v.id, v.opc, v.a, v.b, v.c, v.d);
    #1;
    chk("vec_ready", v.id ? bus1.req1_ready : bus1.req0_ready, 1);
    @(negedge clk);
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    lat = 1;
    while (!bus1.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("vec_latency", lat, v.lat);
    chk("vec_rsp_id", bus1.rsp_id, v.id);
    chk("vec_rsp", {bus1.rsp_err, bus1.rsp_y, bus1.rsp_r, bus1.rsp_a}, {v.err, v.y, v.r, v.av});
    chk("vec_op_opcode", bus1.op_opcode, v.op_opc);
    @(negedge clk);
    chk("vec_back_idle", {bus1.rsp_valid, bus1.busy}, 0);
  endtask

  vec_t        vecs[6];
  logic [11:0] sb_q[$];

  initial begin
    logic        prev;
    logic        m_last;
    logic        outstanding;
    logic        v0, v1, win, e0, e1;
    logic [4:0]  o0, o1;
    logic [2:0]  c0, c1, d0, d1;
    logic        a0, a1, b0, b1;
    logic [10:0] exp4;
    int          cyc, last_cyc, grants, n1, lat;

    //        id  opc     a     b     c     d     err   y     r       av    op_opc  lat
    vecs[0] = '{1'b0, 5'd0,  1'b1, 1'b0, 3'd5, 3'd1, 1'b0, 1'b1, 6'd41, 3'd4, 5'd0,  2};
    vecs[1] = '{1'b1, 5'd3,  1'b1, 1'b1, 3'd7, 3'd7, 1'b0, 1'b1, 6'd2,  3'd0, 5'd3,  2};
    vecs[2] = '{1'b0, 5'd22, 1'b0, 1'b1, 3'd2, 3'd6, 1'b0, 1'b1, 6'd44, 3'd4, 5'd22, 2};
    vecs[3] = '{1'b1, 5'd24, 1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 1'b0, 6'd0,  3'd0, 5'd22, 1};
    vecs[4] = '{1'b0, 5'd31, 1'b1, 1'b0, 3'd1, 3'd1, 1'b1, 1'b0, 6'd0,  3'd0, 5'd22, 1};
    vecs[5] = '{1'b1, 5'd9,  1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 6'd13, 3'd4, 5'd9,  2};

    drive1(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0);
    bus1.req0_valid = 1'b0;
    bus1.rsp_ready  = 1'b0;
    bus3.req0_valid = 1'b0; bus3.req0_opcode = '0; bus3.req0_a = 1'b0; bus3.req0_b = 1'b0;
    bus3.req0_c = '0; bus3.req0_d = '0;
    bus3.req1_valid = 1'b0; bus3.req1_opcode = '0; bus3.req1_a = 1'b0; bus3.req1_b = 1'b0;
    bus3.req1_c = '0; bus3.req1_d = '0;
    bus3.rsp_ready  = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");
    #1;
    chk("reset_ready_idle", {bus1.req1_ready, bus1.req0_ready}, 0);

    // Single commands, including illegal opcodes that must not re-drive the operator.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both requesters always valid: strict alternation, one grant every 3 cycles.
    @(negedge clk);
    bus1.rsp_ready = 1'b1;
    drive1(1'b0, 5'd1, 1'b1, 1'b1, 3'd2, 3'd3);
    bus1.req1_valid = 1'b1;
    prev = 1'b1;
    cyc = 0; last_cyc = 0; grants = 0; n1 = 0;
    while (grants < 20 && cyc < 200) begin
      #1;
      if (bus1.req0_ready || bus1.req1_ready) begin
        chk("rr_alternate", bus1.req1_ready, !prev);
        if (grants > 0) chk("rr_gap", cyc - last_cyc, 3);
        prev = bus1.req1_ready;
        n1 += int'(bus1.req1_ready);
        last_cyc = cyc;
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rr_grants", grants, 20);
    chk("rr_fair", n1, 10);
    drain1();

    // Response back-pressure: outputs frozen, no grants, grant the cycle after the handshake.
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    drive1(1'b0, 5'd2, 1'b1, 1'b0, 3'd4, 3'd2);
    exp4 = f_rsp(5'd2, 1'b1, 1'b0, 3'd4, 3'd2);
    #1;
    chk("bp_accept", bus1.req0_ready, 1);
    @(negedge clk);
    bus1.req1_valid = 1'b1;
    lat = 1;
    while (!bus1.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready_low", {bus1.req1_ready, bus1.req0_ready}, 0);
      chk("bp_rsp_stable", {bus1.rsp_valid, bus1.rsp_id, bus1.rsp_err, bus1.rsp_y, bus1.rsp_r,
                            bus1.rsp_a}, {2'b10, exp4});
      @(negedge clk);
    end
    bus1.rsp_ready = 1'b1;
    #1;
    chk("bp_handshake_cycle_no_grant", {bus1.req1_ready, bus1.req0_ready}, 0);
    @(negedge clk);
    #1;
    chk("bp_next_grant", {bus1.req1_ready, bus1.req0_ready}, 2'b10);
    @(negedge clk);
    drain1();

    // SETTLE=3: capture only after three settle cycles; early glitches must be ignored.
    @(negedge clk);
    bus3.rsp_ready  = 1'b1;
    bus3.req0_valid = 1'b1; bus3.req0_opcode = 5'd1; bus3.req0_a = 1'b1; bus3.req0_b = 1'b1;
    bus3.req0_c = 3'd2; bus3.req0_d = 3'd5;
    #1;
    chk("s3_accept", bus3.req0_ready, 1);
    @(negedge clk);
    bus3.req0_valid = 1'b0;
    corrupt3 = 1'b1;
    lat = 1;
    while (!bus3.rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 3) corrupt3 = 1'b0;
    end
    corrupt3 = 1'b0;
    chk("s3_latency", lat, 4);
    chk("s3_rsp", {bus3.rsp_id, bus3.rsp_err, bus3.rsp_y, bus3.rsp_r, bus3.rsp_a},
        {1'b0, f_rsp(5'd1, 1'b1, 1'b1, 3'd2, 3'd5)});
    @(negedge clk);
    chk("s3_done", {bus3.rsp_valid, bus3.busy}, 0);

    // Reset while waiting on the operator.
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    drive1(1'b1, 5'd5, 1'b1, 1'b1, 3'd3, 3'd6);
    @(negedge clk);
    chk("rst_wait_pre", {bus1.busy, bus1.op_opcode}, {1'b1, 5'd5});
    bus1.req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_wait");
    bus1.req0_valid = 1'b1;
    bus1.req1_valid = 1'b1;
    #1;
    chk("rst_wait_first_grant", {bus1.req1_ready, bus1.req0_ready}, 2'b01);

    // Reset while holding a response.
    @(negedge clk);
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    lat = 1;
    while (!bus1.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_resp_pre", bus1.rsp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_resp");
    bus1.req0_valid = 1'b1;
    bus1.req1_valid = 1'b1;
    #1;
    chk("rst_resp_first_grant", {bus1.req1_ready, bus1.req0_ready}, 2'b01);
    drain1();

    // Randomized traffic against a transaction scoreboard.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
    outstanding = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 6);
      o0 = 5'($urandom); o1 = 5'($urandom);
      a0 = 1'($urandom); a1 = 1'($urandom); b0 = 1'($urandom); b1 = 1'($urandom);
      c0 = 3'($urandom); c1 = 3'($urandom); d0 = 3'($urandom); d1 = 3'($urandom);
      bus1.req0_valid = v0; bus1.req0_opcode = o0; bus1.req0_a = a0; bus1.req0_b = b0;
      bus1.req0_c = c0; bus1.req0_d = d0;
      bus1.req1_valid = v1; bus1.req1_opcode = o1; bus1.req1_a = a1; bus1.req1_b = b1;
      bus1.req1_c = c1; bus1.req1_d = d1;
      bus1.rsp_ready = ($urandom_range(0, 9) < 6);
      #1;
      win = (v0 && v1) ? !m_last : v1;
      e0 = !outstanding && (v0 || v1) && !win;
      e1 = !outstanding && (v0 || v1) && win;
      chk("rnd_ready", {bus1.req1_ready, bus1.req0_ready}, {e1, e0});
      if (bus1.rsp_valid) begin
        if (sb_q.size() == 0) chk("rnd_spurious_rsp", bus1.rsp_valid, 0);
        else if (bus1.rsp_ready) begin
          chk("rnd_rsp", {bus1.rsp_id, bus1.rsp_err, bus1.rsp_y, bus1.rsp_r, bus1.rsp_a},
              sb_q.pop_front());
          outstanding = 1'b0;
        end
      end
      if ((v0 && bus1.req0_ready) || (v1 && bus1.req1_ready)) begin
        if (bus1.req1_ready) sb_q.push_back({1'b1, f_rsp(o1, a1, b1, c1, d1)});
        else                 sb_q.push_back({1'b0, f_rsp(o0, a0, b0, c0, d0)});
        m_last = bus1.req1_ready;
        outstanding = 1'b1;
      end
    end
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    bus1.rsp_ready  = 1'b1;
    for (int t = 0; t < 10 && sb_q.size() > 0; t++) begin
      @(negedge clk);
      #1;
      if (bus1.rsp_valid) begin
        chk("rnd_drain_rsp", {bus1.rsp_id, bus1.rsp_err, bus1.rsp_y, bus1.rsp_r, bus1.rsp_a},
            sb_q.pop_front());
      end
    end
    chk("rnd_all_responded", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
